// File: rtl/arch_cdc_stable_capture.sv
// Stability qualifier for words coming out of a bit-wise CDC synchroniser array.
// A word is accepted once it holds for STABLE_CYCLES edges; each accepted change becomes a single-entry stream event.
module arch_cdc_stable_capture #(
    parameter int               WIDTH         = 2,
    parameter int               STABLE_CYCLES = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE   = '0
) (
    input  logic             dst_clk,
    input  logic             dst_aresetn,
    input  logic [WIDTH-1:0] sync_data,
    output logic [WIDTH-1:0] stable_data,
    output logic             settling,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic [WIDTH-1:0] m_tdata,
    output logic             overrun,
    input  logic             clr_overrun
);
    localparam int            CW      = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_PRE = CW'(STABLE_CYCLES - 1);

    typedef enum logic {TRACK, STABLE} state_t;

    typedef struct packed {
        logic             vld;
        logic [WIDTH-1:0] data;
    } evt_t;

    logic [WIDTH-1:0] last_sample;
    logic [CW-1:0]    cnt;
    state_t           state;
    evt_t             evt;
    logic [WIDTH-1:0] diff;
    logic             same;
    logic             commit;
    logic             ovr_set;

    for (genvar i = 0; i < WIDTH; i++) begin : g_diff
        assign diff[i] = sync_data[i] ^ last_sample[i];
    end

    assign same    = ~|diff;
    // Commit on the edge that would saturate the counter, but only for a real change.
    assign commit  = same && (cnt == CNT_PRE) && (last_sample != stable_data);
    assign ovr_set = commit && evt.vld && !m_tready;

    assign settling = (state == TRACK);
    assign m_tvalid = evt.vld;
    assign m_tdata  = evt.data;

    always_ff @(posedge dst_clk or negedge dst_aresetn) begin
        if (!dst_aresetn) begin
            last_sample <= RESET_VALUE;
            cnt         <= '0;
            state       <= TRACK;
            stable_data <= RESET_VALUE;
            evt         <= '{vld: 1'b0, data: RESET_VALUE};
            overrun     <= 1'b0;
        end else begin
            if (!same) begin
                last_sample <= sync_data;
                cnt         <= '0;
                state       <= TRACK;
            end else if (cnt < CNT_MAX) begin
                cnt <= cnt + CW'(1);
                if (cnt == CNT_PRE) state <= STABLE;
            end

            if (commit) begin
                stable_data <= last_sample;
                evt         <= '{vld: 1'b1, data: last_sample};
            end else if (evt.vld && m_tready) begin
                evt.vld <= 1'b0;
            end

            // Set beats clear when both land on the same edge.
            overrun <= ovr_set | (overrun & ~clr_overrun);
        end
    end
endmodule

// File: tb/tb_arch_cdc_stable_capture.sv
// Scoreboarded bench for arch_cdc_stable_capture (WIDTH=2, STABLE_CYCLES=4).
// Accepted transfers are popped from a queue of expected values at each handshake.
module tb_arch_cdc_stable_capture;
    localparam int W  = 2;
    localparam int SC = 4;

    logic         dst_clk = 1'b0;
    logic         dst_aresetn;
    logic [W-1:0] sync_data;
    logic [W-1:0] stable_data;
    logic         settling;
    logic         m_tvalid;
    logic         m_tready;
    logic [W-1:0] m_tdata;
    logic         overrun;
    logic         clr_overrun;

    int n_chk = 0;
    int n_err = 0;
    logic [W-1:0] exp_q[$];

    always #5 dst_clk = ~dst_clk;

    arch_cdc_stable_capture #(.WIDTH(W), .STABLE_CYCLES(SC), .RESET_VALUE('0)) dut (
        .dst_clk    (dst_clk),
        .dst_aresetn(dst_aresetn),
        .sync_data  (sync_data),
        .stable_data(stable_data),
        .settling   (settling),
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready),
        .m_tdata    (m_tdata),
        .overrun    (overrun),
        .clr_overrun(clr_overrun)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge dst_clk);
            #1;
        end
    endtask

    // Handshake happens on the coming posedge; inputs only move #1 after posedge.
    always @(negedge dst_clk) begin
        if (dst_aresetn === 1'b1 && m_tvalid === 1'b1 && m_tready === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_event", 32'(m_tdata), 32'hFFFF_FFFF);
            end else begin
                chk("event_data", 32'(m_tdata), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        dst_aresetn = 1'b0;
        sync_data   = '0;
        m_tready    = 1'b0;
        clr_overrun = 1'b0;
        tick(2);
        chk("rst_stable", 32'(stable_data), 32'd0);
        chk("rst_settling", 32'(settling), 32'd1);
        chk("rst_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst_tdata", 32'(m_tdata), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);

        // Reset release with input at RESET_VALUE: settle, no event.
        dst_aresetn = 1'b1;
        for (int i = 1; i <= SC + 2; i++) begin
            tick();
            chk("init_settling", 32'(settling), (i < SC) ? 32'd1 : 32'd0);
            chk("init_tvalid", 32'(m_tvalid), 32'd0);
        end
        chk("init_stable", 32'(stable_data), 32'd0);

        // 0 -> 2 with consumer ready: one-cycle event after edge SC.
        m_tready  = 1'b1;
        sync_data = 2'd2;
        exp_q.push_back(2'd2);
        for (int e = 0; e < SC; e++) begin
            tick();
            chk("q2_tvalid_early", 32'(m_tvalid), 32'd0);
            chk("q2_settling", 32'(settling), 32'd1);
        end
        tick();
        chk("q2_tvalid", 32'(m_tvalid), 32'd1);
        chk("q2_tdata", 32'(m_tdata), 32'd2);
        chk("q2_stable", 32'(stable_data), 32'd2);
        chk("q2_settling_fall", 32'(settling), 32'd0);
        tick();
        chk("q2_tvalid_drop", 32'(m_tvalid), 32'd0);

        // Glitch 2 -> 1 for 3 cycles -> back to 2: no event.
        sync_data = 2'd1;
        tick();
        chk("gl_settling_up", 32'(settling), 32'd1);
        tick(2);
        sync_data = 2'd2;
        for (int e = 0; e <= SC; e++) begin
            tick();
            chk("gl_tvalid", 32'(m_tvalid), 32'd0);
            chk("gl_settling", 32'(settling), (e < SC) ? 32'd1 : 32'd0);
        end
        chk("gl_stable", 32'(stable_data), 32'd2);

        // Overwrite while stalled: 1 replaced by 3, overrun set.
        m_tready  = 1'b0;
        sync_data = 2'd1;
        tick(SC + 1);
        chk("ov_first_tvalid", 32'(m_tvalid), 32'd1);
        chk("ov_first_tdata", 32'(m_tdata), 32'd1);
        chk("ov_first_overrun", 32'(overrun), 32'd0);
        sync_data = 2'd3;
        tick(SC);
        chk("ov_hold_tdata", 32'(m_tdata), 32'd1);
        tick();
        chk("ov_tdata", 32'(m_tdata), 32'd3);
        chk("ov_tvalid", 32'(m_tvalid), 32'd1);
        chk("ov_overrun", 32'(overrun), 32'd1);
        tick(2);
        chk("ov_stall_tdata", 32'(m_tdata), 32'd3);
        exp_q.push_back(2'd3);
        m_tready = 1'b1;
        tick();
        chk("ov_drain", 32'(m_tvalid), 32'd0);
        chk("ov_sticky", 32'(overrun), 32'd1);
        m_tready = 1'b0;

        // Clear on the same edge as a new overwrite: set wins.
        sync_data = 2'd0;
        tick(SC + 1);
        chk("clr_pend_tdata", 32'(m_tdata), 32'd0);
        sync_data = 2'd2;
        tick(SC);
        clr_overrun = 1'b1;
        tick();
        chk("clr_set_wins", 32'(overrun), 32'd1);
        chk("clr_ow_tdata", 32'(m_tdata), 32'd2);
        tick();
        chk("clr_alone", 32'(overrun), 32'd0);
        clr_overrun = 1'b0;
        chk("clr_tvalid_pend", 32'(m_tvalid), 32'd1);

        // Reset mid-qualification of 3 with an event pending.
        sync_data = 2'd3;
        tick(2);
        dst_aresetn = 1'b0;
        #1;
        chk("mrst_stable", 32'(stable_data), 32'd0);
        chk("mrst_tvalid", 32'(m_tvalid), 32'd0);
        chk("mrst_tdata", 32'(m_tdata), 32'd0);
        chk("mrst_overrun", 32'(overrun), 32'd0);
        chk("mrst_settling", 32'(settling), 32'd1);
        tick(2);
        dst_aresetn = 1'b1;
        for (int e = 0; e < SC; e++) begin
            tick();
            chk("mrst_tvalid_early", 32'(m_tvalid), 32'd0);
        end
        tick();
        chk("mrst_tvalid_up", 32'(m_tvalid), 32'd1);
        chk("mrst_tdata_up", 32'(m_tdata), 32'd3);
        chk("mrst_stable_up", 32'(stable_data), 32'd3);
        exp_q.push_back(2'd3);
        m_tready = 1'b1;
        tick(2);
        chk("end_tvalid", 32'(m_tvalid), 32'd0);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
